// File: rtl/cart_pkg.sv
// cart_pkg: shared constants, FSM encoding and mirror-mask helper for the cartridge controller.
package cart_pkg;
    localparam int CART_ADDR_W = 14;
    localparam int CART_MIN_MASK_W = 10;
    localparam logic [7:0] CART_FILL = 8'hFF;
    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} cart_state_e;
    // Smallest power-of-two window (>= 1 KB) that holds the image; an empty cart decodes the full window.
    function automatic logic [CART_ADDR_W-1:0] mask_from_size(input logic [CART_ADDR_W:0] size);
        logic [CART_ADDR_W-1:0] m;
        m = '1;
        if (size != '0)
            for (int i = CART_ADDR_W - 1; i >= CART_MIN_MASK_W; i--)
                if (int'(size) <= (1 << i)) m = CART_ADDR_W'((1 << i) - 1);
        return m;
    endfunction
endpackage

// File: rtl/cartouche_ctrl.sv
// cartouche_ctrl: streams a host ROM image into cartridge RAM and serves mirrored CPU reads.
// Define CART_CLEAR_EN to pre-fill the whole RAM with CART_FILL before each download.
module cartouche_ctrl
    import cart_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   dl_active,
    input  logic                   dl_wr,
    input  logic [24:0]            dl_addr,
    input  logic [7:0]             dl_data,
    output logic                   dl_wait,
    input  logic                   cpu_cs,
    input  logic [CART_ADDR_W-1:0] cpu_addr,
    output logic [7:0]             cpu_data,
    output logic [CART_ADDR_W-1:0] mem_addr_rd,
    input  logic [7:0]             mem_dout,
    output logic [CART_ADDR_W-1:0] mem_addr_wr,
    output logic [7:0]             mem_din,
    output logic                   mem_we,
    output logic                   cart_present,
    output logic [CART_ADDR_W:0]   cart_size,
    output logic                   overflow
);
    cart_state_e state_q, state_d;
    logic act_q, present_q, ovf_q, we_q, sel_q;
    logic [CART_ADDR_W:0] size_q;
    logic [CART_ADDR_W-1:0] wa_q;
    logic [7:0] wd_q;
    logic rise, fall, accept, in_range, restart;
    logic [CART_ADDR_W:0] wr_end;
`ifdef CART_CLEAR_EN
    localparam cart_state_e START = CLEAR;
    logic [CART_ADDR_W-1:0] cnt_q;
`else
    localparam cart_state_e START = LOAD;
`endif

    assign rise = dl_active & ~act_q;
    assign fall = ~dl_active & act_q;
    assign restart = rise && (state_q == IDLE || state_q == DONE);
    assign accept = state_q == LOAD && dl_wr;
    assign in_range = dl_addr[24:CART_ADDR_W] == '0;
    assign wr_end = {1'b0, dl_addr[CART_ADDR_W-1:0]} + 1'b1;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = rise ? START : state_q;
`ifdef CART_CLEAR_EN
            CLEAR: state_d = fall ? DONE : (cnt_q == '1 ? LOAD : CLEAR);
`else
            CLEAR: state_d = LOAD;
`endif
            LOAD: state_d = fall ? DONE : LOAD;
        endcase
    end

    always_comb begin
`ifdef CART_CLEAR_EN
        dl_wait = state_q == CLEAR;
`else
        dl_wait = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_q <= 1'b0;
            sel_q <= 1'b0;
            present_q <= 1'b0;
            ovf_q <= 1'b0;
            size_q <= '0;
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
`ifdef CART_CLEAR_EN
            cnt_q <= '0;
`endif
        end else begin
            act_q <= dl_active;
            sel_q <= cpu_cs & present_q;
            we_q <= 1'b0;
            if (state_q == DONE) present_q <= size_q != '0;
            if (restart) begin
                present_q <= 1'b0;
                ovf_q <= 1'b0;
                size_q <= '0;
            end
`ifdef CART_CLEAR_EN
            cnt_q <= state_q == CLEAR ? cnt_q + 1'b1 : '0;
            if (state_q == CLEAR) begin
                we_q <= 1'b1;
                wa_q <= cnt_q;
                wd_q <= CART_FILL;
            end
`endif
            if (accept && in_range) begin
                we_q <= 1'b1;
                wa_q <= dl_addr[CART_ADDR_W-1:0];
                wd_q <= dl_data;
                if (wr_end > size_q) size_q <= wr_end;
            end
            if (accept && !in_range) ovf_q <= 1'b1;
        end
    end

    // RAM read data arrives one cycle after the address, aligned with sel_q.
    assign cpu_data = sel_q ? mem_dout : CART_FILL;
    assign mem_addr_rd = cpu_addr & mask_from_size(size_q);
    assign mem_addr_wr = wa_q;
    assign mem_din = wd_q;
    assign mem_we = we_q;
    assign cart_present = present_q;
    assign cart_size = size_q;
    assign overflow = ovf_q;
endmodule
